niu_tx_mux_arb: RTL and testbench

//  N-channel AXI-Stream TX packet arbiter in front of the 10G MAC TX path (clk156 domain).

---
 rtl/niu_tx_mux_arb_pkg.sv | 24 ++
 rtl/niu_rr_arbiter.sv | 41 ++++
 rtl/niu_tx_mux_arb.sv | 166 ++++++++++++++++
 tb/tb_niu_tx_mux_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/niu_tx_mux_arb_pkg.sv
// Shared types and helpers for the NIU TX packet mux.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package niu_tx_mux_arb_pkg;

  // Arbiter/transfer state: pick a source, forward its packet, or discard the overlong tail.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // 1518-byte frame carried on a 64-bit bus.
  localparam int MAX_FRAME_BEATS = 190;

  // Ceiling log2 with a floor of 1 so one-entry selects still get a real bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/niu_rr_arbiter.sv
// Round-robin pick: first requester at or after i_rr_ptr, wrapping modulo N_CH.
// Latency: purely combinational.
// Backpressure: none; caller decides when to sample the grant.
module niu_rr_arbiter
  import niu_tx_mux_arb_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int IDX_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0]  i_req,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_valid
);

  logic             w_any_lo;
  logic             w_any_hi;
  logic [IDX_W-1:0] w_idx_lo;
  logic [IDX_W-1:0] w_idx_hi;

  // Lowest requester overall is the wrap-around fallback; lowest at/above the pointer wins.
  always_comb begin
    w_any_lo = 1'b0;
    w_any_hi = 1'b0;
    w_idx_lo = '0;
    w_idx_hi = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_any_lo = 1'b1;
        w_idx_lo = IDX_W'(i);
        if (IDX_W'(i) >= i_rr_ptr) begin
          w_any_hi = 1'b1;
          w_idx_hi = IDX_W'(i);
        end
      end
    end
    o_gnt_valid = w_any_lo;
    o_gnt_idx   = w_any_hi ? w_idx_hi : w_idx_lo;
  end

endmodule

// File: rtl/niu_tx_mux_arb.sv
// N-channel AXIS TX arbiter: packet-atomic round-robin merge with max-length truncation.
// Latency: 1 idle cycle to arbitrate, then zero-latency combinational data path.
// Backpressure: m_axis_tready passes straight to the granted channel; others held off.
module niu_tx_mux_arb
  import niu_tx_mux_arb_pkg::*;
#(
  parameter  int N_CH      = 4,
  parameter  int DATA_W    = 64,
  parameter  int MAX_BEATS = MAX_FRAME_BEATS,
  parameter  int CNT_W     = 32,
  localparam int KEEP_W    = DATA_W / 8,
  localparam int IDX_W     = clog2(N_CH)
) (
  input  logic                    clk156,
  input  logic                    reset,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [N_CH*DATA_W-1:0]  s_axis_tdata,
  input  logic [N_CH*KEEP_W-1:0]  s_axis_tkeep,
  input  logic [N_CH-1:0]         s_axis_tvalid,
  input  logic [N_CH-1:0]         s_axis_tlast,
  output logic [N_CH-1:0]         s_axis_tready,
  output logic [DATA_W-1:0]       m_axis_tdata,
  output logic [KEEP_W-1:0]       m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [IDX_W-1:0]        grant_ch,
  output logic                    busy,
  output logic [N_CH-1:0]         trunc_err,
  input  logic                    err_clr,
  output logic [N_CH*CNT_W-1:0]   pkt_cnt
);

  localparam int BEAT_W = clog2(MAX_BEATS + 1);

  state_e                       r_state;
  state_e                       w_state_nxt;
  logic [IDX_W-1:0]             r_rr_ptr;
  logic [IDX_W-1:0]             r_grant;
  logic [BEAT_W-1:0]            r_beat_cnt;
  logic [N_CH-1:0][CNT_W-1:0]   r_pkt_cnt;
  logic [N_CH-1:0]              r_trunc_err;

  logic [N_CH-1:0][DATA_W-1:0]  w_tdata_arr;
  logic [N_CH-1:0][KEEP_W-1:0]  w_tkeep_arr;
  logic [DATA_W-1:0]            w_g_tdata;
  logic [KEEP_W-1:0]            w_g_tkeep;
  logic                         w_g_tvalid;
  logic                         w_g_tlast;
  logic [N_CH-1:0]              w_req;
  logic [IDX_W-1:0]             w_arb_idx;
  logic                         w_arb_vld;
  logic                         w_at_max;
  logic                         w_xfer_hs;
  logic                         w_pkt_end;
  logic                         w_trunc;
  logic [IDX_W-1:0]             w_grant_inc;

  // Granted channel's view of the input bundle.
  assign w_tdata_arr = s_axis_tdata;
  assign w_tkeep_arr = s_axis_tkeep;
  assign w_g_tdata   = w_tdata_arr[r_grant];
  assign w_g_tkeep   = w_tkeep_arr[r_grant];
  assign w_g_tvalid  = s_axis_tvalid[r_grant];
  assign w_g_tlast   = s_axis_tlast[r_grant];

  // Disabled channels never compete, even with data waiting.
  assign w_req = ch_en & s_axis_tvalid;

  niu_rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
    .i_req       (w_req),
    .i_rr_ptr    (r_rr_ptr),
    .o_gnt_idx   (w_arb_idx),
    .o_gnt_valid (w_arb_vld)
  );

  // Beat MAX_BEATS of a packet always closes it; anything beyond is drained.
  assign w_at_max    = (r_beat_cnt == BEAT_W'(MAX_BEATS - 1));
  assign w_xfer_hs   = (r_state == ST_XFER) && w_g_tvalid && m_axis_tready;
  assign w_pkt_end   = w_xfer_hs && (w_g_tlast || w_at_max);
  assign w_trunc     = w_xfer_hs && !w_g_tlast && w_at_max;
  assign w_grant_inc = (r_grant == IDX_W'(N_CH - 1)) ? '0 : r_grant + 1'b1;

  assign grant_ch  = r_grant;
  assign trunc_err = r_trunc_err;
  assign pkt_cnt   = r_pkt_cnt;

  // State register.
  always_ff @(posedge clk156) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: arbitrate in IDLE, leave XFER on last or forced last, leave DRAIN on source last.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_arb_vld) w_state_nxt = ST_XFER;
      ST_XFER: begin
        if (w_xfer_hs) begin
          if (w_g_tlast)     w_state_nxt = ST_IDLE;
          else if (w_at_max) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: if (w_g_tvalid && w_g_tlast) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: mux granted source in XFER, sink its tail in DRAIN, everything quiet in IDLE.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    busy          = 1'b0;
    case (r_state)
      ST_XFER: begin
        s_axis_tready[r_grant] = m_axis_tready;
        m_axis_tdata  = w_g_tdata;
        m_axis_tkeep  = w_g_tkeep;
        m_axis_tvalid = w_g_tvalid;
        m_axis_tlast  = w_g_tlast | w_at_max;
        busy          = 1'b1;
      end
      ST_DRAIN: begin
        s_axis_tready[r_grant] = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Grant capture, beat counting and round-robin pointer advance after each emitted packet.
  always_ff @(posedge clk156) begin
    if (reset) begin
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE && w_arb_vld) begin
        r_grant    <= w_arb_idx;
        r_beat_cnt <= '0;
      end else if (w_xfer_hs) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_pkt_end) r_rr_ptr <= w_grant_inc;
    end
  end

  // Per-channel packet counters (free-running wrap) and sticky truncation flags; a new flag beats a clear.
  always_ff @(posedge clk156) begin
    if (reset) begin
      r_pkt_cnt   <= '0;
      r_trunc_err <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_pkt_end && r_grant == IDX_W'(i)) r_pkt_cnt[i] <= r_pkt_cnt[i] + 1'b1;
        if (w_trunc && r_grant == IDX_W'(i)) r_trunc_err[i] <= 1'b1;
        else if (err_clr)                    r_trunc_err[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_niu_tx_mux_arb.sv
// Bench for niu_tx_mux_arb: arbitration vector table, directed packet sequences, randomized scoreboard run.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Sources obey AXIS hold rules; the sink's tready is randomized in the stress run.
module tb_niu_tx_mux_arb;

  localparam int N    = 4;
  localparam int MAXB = 190;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    int         prime;
    logic [3:0] en;
    logic [3:0] v;
    logic       exp_busy;
    logic [1:0] exp_grant;
  } vec_t;

  logic             clk156 = 1'b0;
  logic             reset  = 1'b1;
  logic [3:0]       ch_en;
  logic [3:0][63:0] s_tdata;
  logic [3:0][7:0]  s_tkeep;
  logic [3:0]       s_tvalid;
  logic [3:0]       s_tlast;
  logic [3:0]       s_tready;
  logic [63:0]      m_tdata;
  logic [7:0]       m_tkeep;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;
  logic [1:0]       grant_ch;
  logic             busy;
  logic [3:0]       trunc_err;
  logic             err_clr;
  logic [3:0][31:0] pkt_cnt;

  int          n_checks = 0;
  int          n_err    = 0;
  beat_t       src_q[4][$];
  beat_t       exp_q[4][$];
  int          out_cnt[4];
  logic [31:0] exp_pkt[4];
  logic [3:0]  exp_trunc;
  int          grant_log[$];
  bit          mrdy_rand;
  bit          gap_en;
  bit          forbid3;
  int          bad_grant;
  int          pkt_seq;
  logic        obs_busy;
  logic        obs_mvld;
  logic        prev_busy;
  logic [1:0]  obs_grant;

  niu_tx_mux_arb dut (
    .clk156        (clk156),
    .reset         (reset),
    .ch_en         (ch_en),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .grant_ch      (grant_ch),
    .busy          (busy),
    .trunc_err     (trunc_err),
    .err_clr       (err_clr),
    .pkt_cnt       (pkt_cnt)
  );

  always #3 clk156 = ~clk156;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue a packet on a source; expected output is the first MAXB beats with last forced on beat MAXB.
  task automatic push_pkt(input int c, input int len, input bit expect_out);
    beat_t b;
    for (int i = 1; i <= len; i++) begin
      b.d = {8'(c), 16'(pkt_seq), 8'(i), 32'($urandom)};
      b.k = (i == len) ? 8'($urandom_range(1, 255)) : 8'hFF;
      b.l = (i == len);
      src_q[c].push_back(b);
      if (expect_out && i <= MAXB) begin
        b.l = (i == len) || (i == MAXB);
        exp_q[c].push_back(b);
      end
    end
    if (expect_out) begin
      exp_pkt[c] = exp_pkt[c] + 1;
      if (len > MAXB) exp_trunc[c] = 1'b1;
    end
    pkt_seq++;
  endtask

  // One clock: sample and score at the falling edge, then advance sources after the rising edge.
  task automatic step();
    logic [3:0] pop;
    logic       hold;
    beat_t      e;
    int         g;
    @(negedge clk156);
    pop       = '0;
    obs_busy  = busy;
    obs_grant = grant_ch;
    obs_mvld  = m_tvalid;
    if (!reset) begin
      for (int c = 0; c < N; c++) pop[c] = s_tvalid[c] & s_tready[c];
      if (m_tvalid && m_tready) begin
        g = int'(grant_ch);
        if (exp_q[g].size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_extra: unexpected beat on ch%0d data %0h", g, m_tdata);
        end else begin
          e = exp_q[g].pop_front();
          chk($sformatf("sb_beat_ch%0d", g), {m_tdata, m_tkeep, m_tlast}, {e.d, e.k, e.l});
          out_cnt[g]++;
        end
      end
      if (busy && !prev_busy) grant_log.push_back(int'(grant_ch));
      if (forbid3 && busy && grant_ch == 2'd3) bad_grant++;
    end
    prev_busy = busy;
    @(posedge clk156);
    #1;
    for (int c = 0; c < N; c++) begin
      if (pop[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
      hold = s_tvalid[c] && !pop[c];
      if (src_q[c].size() == 0)                               s_tvalid[c] = 1'b0;
      else if (!hold && gap_en && $urandom_range(0, 3) == 0) s_tvalid[c] = 1'b0;
      else                                                    s_tvalid[c] = 1'b1;
      if (src_q[c].size() > 0) begin
        s_tdata[c] = src_q[c][0].d;
        s_tkeep[c] = src_q[c][0].k;
        s_tlast[c] = src_q[c][0].l;
      end
    end
    m_tready = mrdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_until_idle(input logic [3:0] mask, input int budget, input string tag);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = !obs_busy;
      for (int c = 0; c < N; c++)
        if (mask[c] && (src_q[c].size() != 0 || exp_q[c].size() != 0)) done = 1'b0;
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: not idle after %0d cycles", tag, budget);
    end
  endtask

  task automatic do_reset(input string tag);
    reset   = 1'b1;
    err_clr = 1'b0;
    for (int c = 0; c < N; c++) begin
      src_q[c].delete();
      exp_q[c].delete();
      out_cnt[c] = 0;
      exp_pkt[c] = '0;
    end
    exp_trunc = '0;
    s_tvalid  = '0;
    s_tlast   = '0;
    grant_log.delete();
    @(posedge clk156);
    #1;
    chk({tag, "_tready"}, s_tready, 4'b0);
    chk({tag, "_mvalid"}, m_tvalid, 1'b0);
    chk({tag, "_mlast"}, m_tlast, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_grant"}, grant_ch, 2'd0);
    chk({tag, "_pktcnt"}, pkt_cnt, 128'd0);
    chk({tag, "_trunc"}, trunc_err, 4'b0);
    @(posedge clk156);
    #1;
    reset     = 1'b0;
    obs_busy  = 1'b0;
    prev_busy = 1'b0;
  endtask

  initial begin
    vec_t vt[12];
    int   n;
    int   len;

    ch_en     = 4'hF;
    s_tdata   = '0;
    s_tkeep   = '0;
    s_tvalid  = '0;
    s_tlast   = '0;
    m_tready  = 1'b1;
    err_clr   = 1'b0;
    mrdy_rand = 1'b0;
    gap_en    = 1'b0;
    forbid3   = 1'b0;
    bad_grant = 0;
    pkt_seq   = 0;
    obs_busy  = 1'b0;
    obs_mvld  = 1'b0;
    obs_grant = '0;
    prev_busy = 1'b0;

    // {prime channel (-1 none), ch_en, valid sources, busy, grant} one cycle after the request.
    vt[0]  = '{-1, 4'hF,    4'b0000, 1'b0, 2'd0};
    vt[1]  = '{-1, 4'hF,    4'b0100, 1'b1, 2'd2};
    vt[2]  = '{-1, 4'hF,    4'b1010, 1'b1, 2'd1};
    vt[3]  = '{-1, 4'b1101, 4'b0110, 1'b1, 2'd2};
    vt[4]  = '{-1, 4'b0000, 4'b1111, 1'b0, 2'd0};
    vt[5]  = '{-1, 4'b1000, 4'b1111, 1'b1, 2'd3};
    vt[6]  = '{ 2, 4'hF,    4'b1111, 1'b1, 2'd3};
    vt[7]  = '{ 3, 4'hF,    4'b0110, 1'b1, 2'd1};
    vt[8]  = '{ 1, 4'hF,    4'b0011, 1'b1, 2'd0};
    vt[9]  = '{ 0, 4'hF,    4'b0001, 1'b1, 2'd0};
    vt[10] = '{ 2, 4'hF,    4'b0000, 1'b0, 2'd2};
    vt[11] = '{ 1, 4'b1011, 4'b1111, 1'b1, 2'd3};

    do_reset("rst0");

    for (int i = 0; i < 12; i++) begin
      do_reset($sformatf("vec%0d_rst", i));
      ch_en = 4'hF;
      if (vt[i].prime >= 0) begin
        push_pkt(vt[i].prime, 1, 1'b1);
        run_until_idle(4'hF, 20, "prime");
      end
      ch_en = vt[i].en;
      for (int c = 0; c < N; c++) if (vt[i].v[c]) push_pkt(c, 1, 1'b1);
      step();
      step();
      step();
      chk($sformatf("vec%0d_busy", i), obs_busy, vt[i].exp_busy);
      chk($sformatf("vec%0d_grant", i), obs_grant, vt[i].exp_grant);
    end

    // Single 4-beat packet: one arbitration cycle, then 4 beats with last on the 4th.
    do_reset("t1");
    ch_en = 4'hF;
    push_pkt(0, 4, 1'b1);
    step();
    step();
    chk("t1_arb_cycle_mvalid", obs_mvld, 1'b0);
    step();
    chk("t1_first_beat_mvalid", obs_mvld, 1'b1);
    chk("t1_first_beat_grant", obs_grant, 2'd0);
    run_until_idle(4'hF, 50, "t1");
    chk("t1_beats", out_cnt[0], 4);
    chk("t1_pktcnt0", pkt_cnt[0], 32'd1);

    // All four channels with two 2-beat packets each: strict rotation.
    do_reset("t2");
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++) push_pkt(c, 2, 1'b1);
    run_until_idle(4'hF, 200, "t2");
    chk("t2_npkts", grant_log.size(), 8);
    for (int k = 0; k < grant_log.size(); k++)
      chk($sformatf("t2_order%0d", k), grant_log[k], k % 4);
    for (int c = 0; c < N; c++) chk($sformatf("t2_pktcnt%0d", c), pkt_cnt[c], 32'd2);

    // Overlong packet on ch1: truncated at MAXB, tail drained, sticky flag then cleared.
    do_reset("t3");
    push_pkt(1, 200, 1'b1);
    run_until_idle(4'hF, 600, "t3");
    chk("t3_beats", out_cnt[1], MAXB);
    chk("t3_trunc", trunc_err, 4'b0010);
    chk("t3_pktcnt1", pkt_cnt[1], 32'd1);
    err_clr = 1'b1;
    @(posedge clk156);
    #1;
    err_clr = 1'b0;
    chk("t3_trunc_clr", trunc_err, 4'b0000);

    // Exactly MAXB beats with its own last is legal; the next packet is untouched.
    do_reset("t4");
    push_pkt(2, MAXB, 1'b1);
    push_pkt(2, 5, 1'b1);
    run_until_idle(4'hF, 600, "t4");
    chk("t4_trunc", trunc_err, 4'b0000);
    chk("t4_beats", out_cnt[2], MAXB + 5);
    chk("t4_pktcnt2", pkt_cnt[2], 32'd2);

    // Randomized backpressure and source gaps; ch3 has data but is disabled.
    do_reset("t5");
    ch_en     = 4'b0111;
    mrdy_rand = 1'b1;
    gap_en    = 1'b1;
    forbid3   = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      len = ($urandom_range(0, 39) == 0) ? int'($urandom_range(185, 196)) : int'($urandom_range(1, 8));
      push_pkt(p % 3, len, 1'b1);
    end
    for (int p = 0; p < 4; p++) push_pkt(3, 3, 1'b0);
    run_until_idle(4'b0111, 60000, "t5");
    for (int c = 0; c < 3; c++) chk($sformatf("t5_pktcnt%0d", c), pkt_cnt[c], exp_pkt[c]);
    chk("t5_pktcnt3", pkt_cnt[3], 32'd0);
    chk("t5_trunc", trunc_err, exp_trunc);
    chk("t5_ch3_never_granted", bad_grant, 0);
    mrdy_rand = 1'b0;
    gap_en    = 1'b0;
    forbid3   = 1'b0;
    ch_en     = 4'hF;

    // Reset while beat 3 of a ch2 packet is on the bus; pointer must return to ch0.
    do_reset("t6a");
    push_pkt(0, 1, 1'b1);
    run_until_idle(4'hF, 20, "t6a");
    push_pkt(2, 6, 1'b1);
    n = 0;
    while (out_cnt[2] < 2 && n < 50) begin
      step();
      n++;
    end
    chk("t6_reached_beat3", out_cnt[2], 2);
    do_reset("t6_mid");
    push_pkt(0, 1, 1'b1);
    push_pkt(3, 1, 1'b1);
    step();
    step();
    step();
    chk("t6_busy", obs_busy, 1'b1);
    chk("t6_grant_restart", obs_grant, 2'd0);
    run_until_idle(4'hF, 30, "t6b");
    chk("t6_pktcnt0", pkt_cnt[0], 32'd1);
    chk("t6_pktcnt3", pkt_cnt[3], 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
